// File: rtl/rtc_calendar_core_if.sv
// rtc_calendar_core_if: button pulses, alarm settings and binary calendar fields of the watch core
interface rtc_calendar_core_if;
  logic       up_p, down_p, left_p, right_p, enter_p, esc_p, view_date, alarm_en;
  logic [4:0] alarm_hh;
  logic [5:0] alarm_mm;
  logic [6:0] year;
  logic [3:0] month;
  logic [4:0] day, hour, hour_disp;
  logic [5:0] min, sec, blink_mask;
  logic [1:0] field_sel;
  logic       pm, setting, set_date, sec_tick, alarm_hit;
  modport master (
    output up_p, down_p, left_p, right_p, enter_p, esc_p, view_date, alarm_en, alarm_hh, alarm_mm,
    input  year, month, day, hour, min, sec, hour_disp, pm, setting, set_date, field_sel,
           blink_mask, sec_tick, alarm_hit
  );
  modport slave (
    input  up_p, down_p, left_p, right_p, enter_p, esc_p, view_date, alarm_en, alarm_hh, alarm_mm,
    output year, month, day, hour, min, sec, hour_disp, pm, setting, set_date, field_sel,
           blink_mask, sec_tick, alarm_hit
  );
endinterface

// File: rtl/rtc_calendar_core.sv
// rtc_calendar_core: prescaled calendar clock with a single-cycle carry chain, button-driven set mode,
// field blink mask, optional 12-hour display and hh:mm alarm pulse.
module rtc_calendar_core #(
  parameter int TICK_DIV  = 1000000,
  parameter int BLINK_DIV = 500000,
  parameter int YEAR_RST  = 15,
  parameter int HOUR12    = 0
) (
  input logic clk,
  input logic rst_n,
  rtc_calendar_core_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] B_MAX = BW'(BLINK_DIV - 1);
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          ph_q, ph_d, set_q, set_d, sdate_q, sdate_d, tick_q, alarm_q, alarm_d;
  logic [1:0]    sel_q, sel_d;
  logic [6:0]    year_q, year_d;
  logic [3:0]    month_q, month_d;
  logic [4:0]    day_q, day_d, hour_q, hour_d, dim_q;
  logic [5:0]    min_q, min_d, sec_q, sec_d;
  logic          esc_a, en_a, ed_a, lr_a, tick, c_s, c_m, c_h, c_d, c_mo;

  function automatic logic [4:0] dim(input logic [6:0] y, input logic [3:0] m);
    return (m == 4'd2) ? ((y[1:0] == 2'd0) ? 5'd29 : 5'd28) :
           (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
  endfunction

  function automatic logic [6:0] step(input logic [6:0] v, input logic [6:0] lo, input logic [6:0] hi,
                                     input logic inc);
    return inc ? ((v == hi) ? lo : v + 7'd1) : ((v == lo) ? hi : v - 7'd1);
  endfunction

  always_comb begin
    esc_a   = bus.esc_p & set_q;
    en_a    = bus.enter_p & ~set_q;
    ed_a    = set_q & ~bus.esc_p & (bus.up_p ^ bus.down_p);
    lr_a    = set_q & ~bus.esc_p & ~bus.up_p & ~bus.down_p & (bus.left_p ^ bus.right_p);
    tick    = ~set_q & (presc_q == P_MAX);
    dim_q   = dim(year_q, month_q);
    c_s     = sec_q == 6'd59;
    c_m     = c_s & (min_q == 6'd59);
    c_h     = c_m & (hour_q == 5'd23);
    c_d     = c_h & (day_q == dim_q);
    c_mo    = c_d & (month_q == 4'd12);
    presc_d = (set_q | en_a | tick) ? '0 : presc_q + PW'(1);
    bcnt_d  = (en_a | lr_a | ~set_q | (bcnt_q == B_MAX)) ? '0 : bcnt_q + BW'(1);
    ph_d    = (en_a | lr_a) ? 1'b1 : ph_q ^ (set_q & (bcnt_q == B_MAX));
    set_d   = esc_a ? 1'b0 : (en_a | set_q);
    sdate_d = en_a ? bus.view_date : sdate_q;
    sel_d   = en_a ? 2'd2 : ~lr_a ? sel_q :
              bus.left_p ? ((sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1) : ((sel_q == 2'd0) ? 2'd2 : sel_q - 2'd1);
    alarm_d = tick_q & bus.alarm_en & ~set_q & (hour_q == bus.alarm_hh) & (min_q == bus.alarm_mm) &
              (sec_q == 6'd0);
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    if (tick) begin
      sec_d = c_s ? 6'd0 : sec_q + 6'd1;
      if (c_s) min_d = c_m ? 6'd0 : min_q + 6'd1;
      if (c_m) hour_d = c_h ? 5'd0 : hour_q + 5'd1;
      if (c_h) day_d = c_d ? 5'd1 : day_q + 5'd1;
      if (c_d) month_d = c_mo ? 4'd1 : month_q + 4'd1;
      if (c_mo) year_d = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
    end
    if (ed_a && !sdate_q) begin
      if (sel_q == 2'd2) hour_d = 5'(step(7'(hour_q), 7'd0, 7'd23, bus.up_p));
      else if (sel_q == 2'd1) min_d = 6'(step(7'(min_q), 7'd0, 7'd59, bus.up_p));
      else sec_d = 6'(step(7'(sec_q), 7'd0, 7'd59, bus.up_p));
    end
    if (ed_a && sdate_q) begin
      if (sel_q == 2'd2) year_d = step(year_q, 7'd0, 7'd99, bus.up_p);
      else if (sel_q == 2'd1) month_d = 4'(step(7'(month_q), 7'd1, 7'd12, bus.up_p));
      else day_d = 5'(step(7'(day_q), 7'd1, 7'(dim_q), bus.up_p));
      // a new year/month may shorten the month below the current day
      if (day_d > dim(year_d, month_d)) day_d = dim(year_d, month_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      presc_q <= '0;
      bcnt_q  <= '0;
      ph_q    <= 1'b1;
      set_q   <= 1'b0;
      sdate_q <= 1'b0;
      sel_q   <= 2'd2;
      tick_q  <= 1'b0;
      alarm_q <= 1'b0;
      year_q  <= 7'(YEAR_RST);
      month_q <= 4'd1;
      day_q   <= 5'd1;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
    end else begin
      presc_q <= presc_d;
      bcnt_q  <= bcnt_d;
      ph_q    <= ph_d;
      set_q   <= set_d;
      sdate_q <= sdate_d;
      sel_q   <= sel_d;
      tick_q  <= tick;
      alarm_q <= alarm_d;
      year_q  <= year_d;
      month_q <= month_d;
      day_q   <= day_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
    end

  assign bus.year       = year_q;
  assign bus.month      = month_q;
  assign bus.day        = day_q;
  assign bus.hour       = hour_q;
  assign bus.min        = min_q;
  assign bus.sec        = sec_q;
  assign bus.setting    = set_q;
  assign bus.set_date   = sdate_q;
  assign bus.field_sel  = sel_q;
  assign bus.sec_tick   = tick_q;
  assign bus.alarm_hit  = alarm_q;
  assign bus.hour_disp  = (HOUR12 == 0) ? hour_q : (hour_q == 5'd0) ? 5'd12 :
                          (hour_q > 5'd12) ? hour_q - 5'd12 : hour_q;
  assign bus.pm         = (HOUR12 != 0) && (hour_q >= 5'd12);
  assign bus.blink_mask = set_q ? ~(6'({~ph_q, ~ph_q}) << {sel_q, 1'b0}) : 6'h3f;
endmodule

// File: doc/rtc_calendar_core.md
Name: rtc_calendar_core

Overview:
Parametrised timekeeping core for the multi-mode watch: second prescaler, single-cycle sec/min/hour/day/month/year carry chain, leap-year month lengths, and an interactive set mode driven by button pulses.
Also provides a field-blink mask, optional 12-hour display output and an hh:mm alarm match.
Sits between the button edge detectors and the display mux/7-segment decoders. Outputs are binary fields, and digit splitting happens downstream.

Parameters:
TICK_DIV, 1000000, clk cycles per second (>=2)
BLINK_DIV, 500000, clk cycles per blink phase toggle (>=1)
YEAR_RST, 15, year value after reset (0..99, represents 2000+year)
HOUR12, 0, 1 = hour_disp in 12-hour format with pm flag; 0 = hour_disp equals hour

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
up_p  in  1  one-cycle pulse, increment selected field
down_p  in  1  one-cycle pulse, decrement selected field
left_p  in  1  one-cycle pulse, select next-higher field pair
right_p  in  1  one-cycle pulse, select next-lower field pair
enter_p  in  1  one-cycle pulse, enter set mode
esc_p  in  1  one-cycle pulse, leave set mode
view_date  in  1  set target chosen at enter: 1 = date (yy/mm/dd), 0 = time (hh:mm:ss)
alarm_en  in  1  alarm enable
alarm_hh  in  5  alarm hour 0..23
alarm_mm  in  6  alarm minute 0..59
year  out  7  0..99
month  out  4  1..12
day  out  5  1..days-in-month
hour  out  5  0..23
min  out  6  0..59
sec  out  6  0..59
hour_disp  out  5  display hour (1..12 if HOUR12, else = hour)
pm  out  1  hour>=12 when HOUR12, else 0
setting  out  1  set mode active
set_date  out  1  set target latched at enter
field_sel  out  2  2 = high pair (yy/hh), 1 = mid (mm), 0 = low (dd/ss)
blink_mask  out  6  1 = digit visible; bit5..0 = leftmost..rightmost digit
sec_tick  out  1  one-cycle pulse on each second increment
alarm_hit  out  1  one-cycle alarm pulse

Behaviour:
- Reset values (async, rst_n=0):
  - year=YEAR_RST, month=1, day=1, hour=min=sec=0.
  - setting=0, set_date=0, field_sel=2, blink_mask=6'b111111.
  - sec_tick=0, alarm_hit=0.
  - Prescaler=0, blink counter=0, blink_phase=1.
- Prescaler counts 0..TICK_DIV-1 while setting=0. At TICK_DIV-1 it wraps to 0 and sec_tick=1 in the same cycle the fields update (registered, 1-cycle pulse).
- Carry chain completes in that single cycle:
  - sec 59->0 carries to min; min 59->0 carries to hour; hour 23->0 carries to day.
  - day dim->1 carries to month; month 12->1 carries to year; year 99->0.
  - Example: 99/12/31 23:59:59 -> 00/01/01 00:00:00 in one tick.
- dim (days in month):
  - 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11.
  - February: 29 if year[1:0]==0, else 28.
- Set mode:
  - enter_p with setting=0: setting=1, set_date=view_date, field_sel=2, prescaler cleared and held at 0, blink_phase=1, blink counter=0.
  - esc_p with setting=1: setting=0. Prescaler restarts from 0, so the first tick comes TICK_DIV cycles later.
  - enter_p while setting=1 and esc_p while setting=0 are ignored.
- Event priority: one event acted on per cycle, in order esc_p > enter_p > up_p/down_p > left_p/right_p. If up_p and down_p arrive together, both are ignored that cycle.
- left_p: field_sel 0->1->2->0. right_p: 2->1->0->2. Either one reloads blink_phase=1 and clears the blink counter. Both are ignored when setting=0.
- up_p/down_p (setting=1 only) change the selected field by ±1 with wrap inside its legal range:
  - Time target: field 2 = hour 0..23, field 1 = min 0..59, field 0 = sec 0..59.
  - Date target: field 2 = year 0..99, field 1 = month 1..12, field 0 = day 1..dim.
  - A year or month change clamps day to the new dim in the same cycle.
  - No carries are generated by edits.
- Blink:
  - setting=0: blink_mask=6'b111111.
  - setting=1: blink_phase toggles every BLINK_DIV cycles. Bits of the selected pair (field 2 -> [5:4], 1 -> [3:2], 0 -> [1:0]) equal blink_phase; all other bits are 1.
- HOUR12=1: hour_disp is 12 for hour 0 and 12, else hour mod 12; pm=(hour>=12). HOUR12=0: hour_disp=hour, pm=0.
- alarm_hit is a 1-cycle pulse, the cycle after the tick in which the time becomes alarm_hh:alarm_mm:00. Conditions: alarm_en=1 and setting=0. Edits never trigger it.
- Reset mid-operation aborts set mode immediately and restores all reset values.

Test Plan:
- TICK_DIV=4, reset then 240 cycles: sec_tick every 4th cycle; after 60 ticks min=1, sec=0.
- Preload 99/12/31 23:59:59 via set mode, esc, wait 4 cycles: all fields = 00/01/01 00:00:00 in the same cycle as sec_tick.
- Date set on year 15, month 3, day 31: down_p on month gives month=2, day=28. Then year up to 16 (field 2), month field up/down back to 2: day stays 28, and Feb 29 becomes reachable via day up.
- Time set: field_sel=2; right_p, right_p gives 0; up_p at sec=59 gives sec=0 and min unchanged. up_p and down_p in the same cycle: no change. esc_p and up_p together: exit only, no edit.
- BLINK_DIV=2, setting with field_sel=1: blink_mask alternates 6'b110011 / 6'b111111 every 2 cycles. After left_p, field_sel=2 and mask shows 6'b001111 with blink_phase reloaded to 1 (6'b111111 first).
- HOUR12=1, alarm 13:05 enabled: tick from 13:04:59 gives hour_disp=1, pm=1, and alarm_hit high exactly one cycle after sec_tick. With setting=1 at the same time, no alarm_hit.
